// File: rtl/instr_encoder.sv
// RV32I field-to-instruction encoder with immediate range checks and sequential word addressing.
// Latency: one cycle from input accept to out_valid; full throughput through a single register stage.
// Backpressure: in_ready = !out_valid || out_ready; a stalled word holds instr/addr/err stable.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int ERRCNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [4:0]          rd,
  input  logic [31:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_SYS   = 5'b11100;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam logic [4:0] OP_BR    = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_t;

  enc_t              enc;
  logic              fits_i, fits_b, fits_j, fits_sh, fits_u;
  logic [31:0]       i_word;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] word_addr;
  logic              fire_in, fire_out;

  // A value fits an N-bit signed field when every bit above the field's sign bit matches it.
  assign fits_i  = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fits_j  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
  assign fits_sh = ~(|imm[31:5]);
  assign fits_u  = ~(|imm[11:0]);

  assign i_word = {imm[11:0], rs1, funct3, rd, opcode, 2'b11};

  always_comb begin
    enc.instr = i_word;
    enc.err   = 1'b0;
    case (opcode)
      OP_R: begin
        enc.instr = {funct7, rs2, rs1, funct3, rd, opcode, 2'b11};
      end
      OP_IMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          enc.instr = {funct7, imm[4:0], rs1, funct3, rd, opcode, 2'b11};
          enc.err   = ~fits_sh;
        end else begin
          enc.err = ~fits_i;
        end
      end
      OP_LOAD, OP_JALR, OP_SYS: begin
        enc.err = ~fits_i;
      end
      OP_STORE: begin
        enc.instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode, 2'b11};
        enc.err   = ~fits_i;
      end
      OP_BR: begin
        enc.instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode, 2'b11};
        enc.err   = ~fits_b;
      end
      OP_JAL: begin
        enc.instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode, 2'b11};
        enc.err   = ~fits_j;
      end
      OP_LUI, OP_AUIPC: begin
        enc.instr = {imm[31:12], rd, opcode, 2'b11};
        enc.err   = ~fits_u;
      end
      default: begin
        enc.err = 1'b1;
      end
    endcase
  end

  assign in_ready  = !out_valid || out_ready;
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;
  // start in the accept cycle restarts numbering at this very word.
  assign word_addr = start ? BASE : next_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
      out_addr  <= BASE;
      next_addr <= BASE;
      err_count <= '0;
    end else begin
      if (fire_in) begin
        out_valid <= 1'b1;
        out_instr <= enc.instr;
        out_err   <= enc.err;
        out_addr  <= word_addr;
        next_addr <= word_addr + ADDR_W'(1);
      end else begin
        if (fire_out) out_valid <= 1'b0;
        if (start)    next_addr <= BASE;
      end
      if (start)
        err_count <= '0;
      else if (fire_out && out_err && !(&err_count))
        err_count <= err_count + ERRCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed literal vectors plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_instr_encoder;
  localparam int AW = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]  opcode = '0, rs1 = '0, rs2 = '0, rd = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_instr;
  logic [AW-1:0] out_addr;
  logic [7:0]  err_count;

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder: plain shift/mask arithmetic per format, range checks as integer compares.
  function automatic void encode(input logic [31:0] op, f3, f7, r1, r2, d, im,
                                 output logic [31:0] w, output bit e);
    int s;
    logic [31:0] regs;
    s = $signed(im);
    regs = (r1 << 15) | (f3 << 12) | (d << 7);
    w = ((im & 32'hfff) << 20) | regs;
    e = 1'b1;
    case (op)
      32'h0C: begin w = (f7 << 25) | (r2 << 20) | regs; e = 0; end
      32'h04: begin
        if (f3 == 1 || f3 == 5) begin
          w = (f7 << 25) | ((im & 31) << 20) | regs;
          e = (im > 31);
        end else e = !(s >= -2048 && s <= 2047);
      end
      32'h00, 32'h19, 32'h1C: e = !(s >= -2048 && s <= 2047);
      32'h08: begin
        w = (((im >> 5) & 127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | ((im & 31) << 7);
        e = !(s >= -2048 && s <= 2047);
      end
      32'h18: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (r2 << 20) | (r1 << 15)
          | (f3 << 12) | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7);
        e = !(s >= -4096 && s <= 4094 && (s % 2) == 0);
      end
      32'h1B: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20)
          | (((im >> 12) & 255) << 12) | (d << 7);
        e = !(s >= -1048576 && s <= 1048574 && (s % 2) == 0);
      end
      32'h0D, 32'h05: begin w = (im & 32'hfffff000) | (d << 7); e = ((im & 4095) != 0); end
      default: ;
    endcase
    w = w | (op << 2) | 3;
  endfunction

  typedef struct { logic [31:0] w; bit e; int a; } exp_t;
  exp_t q[$];
  int   m_next = 0, m_cnt = 0;
  bit   chk_en = 0;
  logic [31:0] log_w[$];
  int   log_a[$];
  bit   log_e[$];
  int   rdy_low = 0;

  // Single compare process: checks DUT against model, then advances model with this cycle's inputs.
  always @(negedge clk) begin
    exp_t x;
    logic [31:0] w;
    bit e, hs, acc;
    int a;
    if (chk_en) begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, (q.size() == 0) || out_ready);
      check("err_count", err_count, m_cnt);
      if (q.size() != 0) begin
        check("out_instr", out_instr, q[0].w);
        check("out_addr", out_addr, q[0].a);
        check("out_err", out_err, q[0].e);
      end
      if (rst_n && out_valid && out_ready) begin
        log_w.push_back(out_instr); log_a.push_back(int'(out_addr)); log_e.push_back(out_err);
      end
      if (!in_ready) rdy_low++;
    end
    if (!rst_n) begin
      q.delete(); m_next = 0; m_cnt = 0; chk_en = 1;
    end else if (chk_en) begin
      hs  = (q.size() != 0) && out_ready;
      acc = in_valid && ((q.size() == 0) || out_ready);
      if (hs) begin
        if (q[0].e && m_cnt < 255) m_cnt++;
        void'(q.pop_front());
      end
      if (start) m_cnt = 0;
      if (acc) begin
        a = start ? 0 : m_next;
        encode(opcode, funct3, funct7, rs1, rs2, rd, imm, w, e);
        x.w = w; x.e = e; x.a = a;
        q.push_back(x);
        m_next = (a + 1) % (1 << AW);
      end else if (start) m_next = 0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                      input logic [31:0] im);
    int n = 0;
    opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = d; imm = im;
    in_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!in_ready && n < 200);
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic clear_log();
    log_w.delete(); log_a.delete(); log_e.delete();
  endtask

  task automatic chk_log(input int i, input logic [31:0] w, input int a, input bit e);
    if (i < log_w.size()) begin
      check($sformatf("log%0d_instr", i), log_w[i], w);
      check($sformatf("log%0d_addr", i), log_a[i], a);
      check($sformatf("log%0d_err", i), log_e[i], e);
    end else check($sformatf("log%0d_missing", i), 0, 1);
  endtask

  initial begin
    logic [31:0] w;
    bit e;
    int bnd[15] = '{2047, 2048, -2048, -2049, 31, 32, 4094, 4095, 4096, -4096, -4097,
                    1048574, 1048575, -1048576, -1048578};
    logic [4:0] ops[11] = '{5'h0C, 5'h04, 5'h00, 5'h19, 5'h1C, 5'h08, 5'h18, 5'h1B, 5'h0D, 5'h05, 5'h1F};

    // Pin the model with hand-computed words.
    encode(32'h04, 0, 0, 0, 0, 1, 5, w, e);         check("model_addi", {w, 7'b0, e}, {32'h00500093, 8'h0});
    encode(32'h18, 0, 0, 0, 0, 0, -4, w, e);        check("model_beq", {w, 7'b0, e}, {32'hFE000EE3, 8'h0});
    encode(32'h04, 5, 32'h20, 2, 0, 3, 7, w, e);    check("model_srai", {w, 7'b0, e}, {32'h40715193, 8'h0});
    encode(32'h18, 0, 0, 0, 0, 0, 4096, w, e);      check("model_b_oor", e, 1);

    // Reset state.
    idle(2); rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    clear_log();
    send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
    @(negedge clk);
    check("addi_instr_lat1", out_instr, 32'h00500093);
    check("addi_valid_lat1", out_valid, 1);
    idle(2);
    chk_log(0, 32'h00500093, 0, 0);

    pulse_start(); clear_log(); rdy_low = 0;
    send(5'b01000, 3'b010, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
    send(5'b11000, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4);
    send(5'b11011, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'h800);
    send(5'b01101, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'h12345000);
    idle(2);
    check("b2b_in_ready_low_cycles", rdy_low, 0);
    chk_log(0, 32'h0020A423, 0, 0);
    chk_log(1, 32'hFE000EE3, 1, 0);
    chk_log(2, 32'h001000EF, 2, 0);
    chk_log(3, 32'h123452B7, 3, 0);

    pulse_start(); clear_log();
    send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048); idle(2);
    check("err_cnt_1", err_count, 1);
    send(5'b11000, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3); idle(2);
    check("err_cnt_2", err_count, 2);
    send(5'b11111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0); idle(2);
    check("err_cnt_3", err_count, 3);
    check("err_flags", {log_e[0], log_e[1], log_e[2]}, 3'b111);
    for (int i = 0; i < 300; i++) send(5'b11111, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle(2);
    check("err_cnt_sat", err_count, 255);

    // Backpressure: one word stalls for 5 cycles with the next bundle waiting.
    pulse_start(); clear_log();
    check("start_clears_cnt", err_count, 0);
    out_ready = 1'b0;
    send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd2, 32'd7);
    opcode = 5'b00100; funct3 = 0; rs1 = 0; rd = 5'd3; imm = 32'd9; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_instr", out_instr, 32'h00700113);
      check("stall_addr", out_addr, 0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    idle(3);
    check("stall_log_len", log_w.size(), 2);
    chk_log(0, 32'h00700113, 0, 0);
    chk_log(1, 32'h00900193, 1, 0);

    // Wrap of the 3-bit address counter.
    pulse_start(); clear_log();
    for (int i = 0; i < 9; i++) send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'(i), 32'(i));
    idle(2);
    check("wrap_len", log_w.size(), 9);
    for (int i = 0; i < 9 && i < log_a.size(); i++) check($sformatf("wrap_addr%0d", i), log_a[i], i % 8);

    // start coinciding with a handshake: next word restarts at base.
    clear_log();
    send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd4, 32'd1);
    pulse_start();
    send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd5, 32'd2);
    idle(2);
    chk_log(0, 32'h00100213, 1, 0);
    chk_log(1, 32'h00200293, 0, 0);

    // Reset while a word is stalled drops it.
    out_ready = 1'b0;
    send(5'b00100, 3'b000, 7'd0, 5'd0, 5'd0, 5'd6, 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_stall_valid", out_valid, 0);
    check("rst_stall_addr", out_addr, 0);
    rst_n = 1'b1; out_ready = 1'b1;
    idle(1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int k;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 49) == 0);
      opcode = ops[$urandom_range(0, 10)];
      if (opcode == 5'h1F) opcode = 5'($urandom);
      funct3 = 3'($urandom); funct7 = 7'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      k = $urandom_range(0, 5);
      case (k)
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 80)) - 32'd40;
        2: imm = 32'(bnd[$urandom_range(0, 14)]);
        3: imm = $urandom & 32'hFFFFF000;
        4: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
        default: imm = 32'($urandom_range(0, 31));
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's immediate/field decoder. Takes decoded fields (opcode, registers, funct3/funct7, 32-bit immediate) and produces the packed RV32I instruction word.
- Range-checks the immediate against the target format.
- Emits encoded words with sequential word addresses through a registered valid/ready stage. Used by the instruction-memory loader and the self-test program generator.

Parameters:
- ADDR_W, 10, width of the output word-address counter.
- BASE_ADDR, 0, word address loaded into the counter on reset and on start.
- ERRCNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse: reload address counter to BASE_ADDR, clear err_count
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle this cycle
- opcode  input  5  instr[6:2] value
- funct3  input  3  function field
- funct7  input  7  function field (R-type and shift-immediates only)
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- rd  input  5  destination register
- imm  input  32  full-width immediate value (byte offset for B/J; full value for U)
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts the word
- out_instr  output  32  encoded instruction; bits[1:0] always 2'b11
- out_addr  output  ADDR_W  word address of out_instr
- out_err  output  1  this word failed a range or opcode check
- err_count  output  ERRCNT_W  saturating count of emitted words with out_err=1

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_instr=0, out_err=0, err_count=0, out_addr=BASE_ADDR.
  - in_ready=1 from the first cycle after reset.
  - Reset overrides everything, including a word held under backpressure; that word is dropped.
- Handshakes:
  - in_ready = !out_valid || out_ready (single register stage, full throughput).
  - Input accepted when in_valid && in_ready. The encoded word is registered and out_valid=1 the next cycle (latency 1).
  - While out_valid && !out_ready, out_instr, out_addr and out_err hold stable.
- Address counter:
  - out_addr advances by 1 on each output handshake (out_valid && out_ready), wrapping modulo 2^ADDR_W.
  - The first accepted word after reset or start carries BASE_ADDR.
- start:
  - Reloads the counter and clears err_count.
  - If a handshake completes in the same cycle, start wins: the next word carries BASE_ADDR.
  - start does not drop a pending word.
- Formats, selected by opcode:
  - R 01100: {funct7,rs2,rs1,funct3,rd,op,2'b11}.
  - I 00100/00000/11001/11100: {imm[11:0],rs1,funct3,rd,op,11}.
  - Shift-immediate: opcode 00100 with funct3 001/101 uses {funct7,imm[4:0]} in place of imm[11:0].
  - S 01000: {imm[11:5],rs2,rs1,funct3,imm[4:0],op,11}.
  - B 11000: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op,11}.
  - J 11011: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op,11}.
  - U 01101/00101: {imm[31:12],rd,op,11}.
- Range checks (out_err=1 if violated; word is still emitted with the truncated encoding):
  - I/S: imm within -2048..2047.
  - Shift: imm within 0..31.
  - B: imm within -4096..4094 and imm[0]=0.
  - J: imm within -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm ignored, never an error.
- Unknown opcode: out_err=1, encoded as I-type.
- err_count increments on each output handshake with out_err=1 and saturates at all-ones.

Test Plan:
- Reset then opcode 00100, f3 000, rd 1, rs1 0, imm 5 -> out_instr 0x00500093, out_addr 0, out_err 0, one cycle after accept.
- Back-to-back inputs with out_ready=1: S-type (f3 010, rs1 1, rs2 2, imm 8) then B-type (f3 000, rs1 0, rs2 0, imm -4) -> 0x0020A423 at addr 0, then 0xFE000EE3 at addr 1; in_ready stays 1.
- J-type rd 1, imm 0x800 -> 0x001000EF. U-type opcode 01101, rd 5, imm 0x12345000 -> 0x123452B7. Both with out_err 0.
- Errors: I-type imm 2048 -> out_err 1, err_count 1. B-type imm 3 -> out_err 1, err_count 2. opcode 11111 -> out_err 1. err_count saturates at 255 after 300 errored words.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable, no address advance. Release -> one word per cycle, no loss or duplication.
- Counter wrap at ADDR_W=3: 9 words -> addresses 0..7, then 0. start asserted with a handshake -> next word at BASE_ADDR. rst_n low mid-stall -> out_valid 0 next cycle.
